// File: rtl/spi_tx_feeder_if.sv
// Host push / SPI interface bundle for spi_tx_feeder.
// Master modport belongs to the host and sender side; slave modport belongs to the feeder.
interface spi_tx_feeder_if #(
  parameter int unsigned AW = 3
) ();
  logic          ENABLE;
  logic          PUSH;
  logic [7:0]    PUSH_DATA;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
  logic          SPI_WRITE;
  logic [7:0]    SPI_DATA;
  logic          SPI_TX_EMPTY;
  logic          BUSY;
  logic          OVERFLOW;
  logic          TIMEOUT_ERR;

  modport master (
    output ENABLE, PUSH, PUSH_DATA, SPI_TX_EMPTY,
    input  FULL, EMPTY, COUNT, SPI_WRITE, SPI_DATA, BUSY, OVERFLOW, TIMEOUT_ERR
  );

  modport slave (
    input  ENABLE, PUSH, PUSH_DATA, SPI_TX_EMPTY,
    output FULL, EMPTY, COUNT, SPI_WRITE, SPI_DATA, BUSY, OVERFLOW, TIMEOUT_ERR
  );
endinterface

// File: rtl/spi_tx_feeder.sv
// Transmit byte FIFO plus pacing sequencer feeding one byte at a time to the SPI block.
// All outputs are registered; the write strobe appears on the edge that leaves LOAD.
module spi_tx_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           CLR,
  spi_tx_feeder_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_cnt_nxt;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          timeout_err;
  logic          spi_write;
  logic [7:0]    spi_data;
  logic          busy;

  logic          push_ok;
  logic          pop;
  logic          write_nxt;
  logic          tmo_hit;

  // FULL is the registered flag, so a push while full is dropped even if a pop happens now
  assign push_ok = bus.PUSH && !full;

  // State register
  always_ff @(posedge CLK) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.ENABLE && !empty && bus.SPI_TX_EMPTY) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!bus.SPI_TX_EMPTY)                    state_nxt = S_WAIT_DONE;
        else if (tmo_cnt == TW'(TIMEOUT - 1))     state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (bus.SPI_TX_EMPTY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state actions: pop and strobe in LOAD, handshake timer in WAIT_ACK
  always_comb begin
    pop         = 1'b0;
    write_nxt   = 1'b0;
    tmo_hit     = 1'b0;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      S_LOAD: begin
        pop         = 1'b1;
        write_nxt   = 1'b1;
        tmo_cnt_nxt = '0;
      end
      S_WAIT_ACK: begin
        if (bus.SPI_TX_EMPTY) begin
          if (tmo_cnt == TW'(TIMEOUT - 1)) tmo_hit = 1'b1;
          else                              tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Occupancy after this edge
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CW'(1);
    else if (!push_ok && pop) count_nxt = count - CW'(1);
  end

  // Storage array; contents are don't-care after reset since the pointers restart
  always_ff @(posedge CLK) begin
    if (!CLR && push_ok) mem[wptr] <= bus.PUSH_DATA;
  end

  // Pointers, status flags and registered outputs
  always_ff @(posedge CLK) begin
    if (CLR) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      tmo_cnt     <= '0;
      spi_write   <= 1'b0;
      spi_data    <= 8'h00;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr     <= rptr + AW'(1);
        spi_data <= mem[rptr];
      end
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      tmo_cnt   <= tmo_cnt_nxt;
      spi_write <= write_nxt;
      busy      <= (state_nxt != S_IDLE);
      if (bus.PUSH && full) overflow    <= 1'b1;
      if (tmo_hit)          timeout_err <= 1'b1;
    end
  end

  assign bus.FULL        = full;
  assign bus.EMPTY       = empty;
  assign bus.COUNT       = count;
  assign bus.SPI_WRITE   = spi_write;
  assign bus.SPI_DATA    = spi_data;
  assign bus.BUSY        = busy;
  assign bus.OVERFLOW    = overflow;
  assign bus.TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder: vector table, directed corner cases and
// randomized traffic against a queue-based reference model with a simple sender model.
module tb_spi_tx_feeder;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  spi_tx_feeder_if #(.AW(AW)) bus ();

  spi_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  byte unsigned mq[$];
  byte unsigned sent_q[$];
  bit  m_ovf    = 1'b0;
  bit  m_tmo    = 1'b0;
  int  tmo_due  = 0;

  // Sender model: drops TX_EMPTY ack_delay cycles after a strobe, raises it shift_len later
  bit  mute      = 1'b0;
  int  ack_delay = 1;
  int  shift_len = 8;
  int  ack_t     = 0;
  int  shift_t   = 0;

  int  cyc         = 0;
  int  last_strobe = -100;
  int  strobe_cnt  = 0;

  typedef struct {
    bit           en;
    bit           push;
    byte unsigned din;
    int           cnt;
    bit           full;
    bit           empty;
    bit           ovf;
    bit           wr;
    bit           busy;
    byte unsigned sdata;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(bit en, bit push, byte unsigned din, int cnt, bit full,
                              bit empty, bit ovf, bit wr, bit busy, byte unsigned sdata);
    vec_t v;
    v.en = en; v.push = push; v.din = din; v.cnt = cnt; v.full = full;
    v.empty = empty; v.ovf = ovf; v.wr = wr; v.busy = busy; v.sdata = sdata;
    vt.push_back(v);
  endfunction

  // One clock: advance past the edge, update sender and model, compare status
  task automatic tick();
    bit full_before;
    @(posedge clk);
    #1;
    cyc++;
    full_before = (mq.size() == DEPTH);
    if (clr) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_tmo   = 1'b0;
      tmo_due = 0;
      chk("clr_write", int'(bus.SPI_WRITE), 0);
    end else if (tmo_due > 0) begin
      if (!bus.SPI_TX_EMPTY) tmo_due = 0;
      else begin
        tmo_due--;
        if (tmo_due == 0) m_tmo = 1'b1;
      end
    end
    if (ack_t > 0) begin
      ack_t--;
      if (ack_t == 0) begin
        bus.SPI_TX_EMPTY = 1'b0;
        shift_t = shift_len;
      end
    end else if (shift_t > 0) begin
      shift_t--;
      if (shift_t == 0) bus.SPI_TX_EMPTY = 1'b1;
    end
    if (!clr) begin
      if (bus.SPI_WRITE) begin
        strobe_cnt++;
        sent_q.push_back(bus.SPI_DATA);
        chk("strobe_spacing", int'((cyc - last_strobe) >= 4), 1);
        last_strobe = cyc;
        chk("strobe_has_data", int'(mq.size() != 0), 1);
        if (mq.size() != 0) chk("strobe_data", int'(bus.SPI_DATA), int'(mq.pop_front()));
        tmo_due = TIMEOUT;
        if (!mute) ack_t = ack_delay;
      end
      if (bus.PUSH) begin
        if (full_before) m_ovf = 1'b1;
        else             mq.push_back(bus.PUSH_DATA);
      end
    end
    chk("count",       int'(bus.COUNT),       mq.size());
    chk("full",        int'(bus.FULL),        int'(mq.size() == DEPTH));
    chk("empty",       int'(bus.EMPTY),       int'(mq.size() == 0));
    chk("overflow",    int'(bus.OVERFLOW),    int'(m_ovf));
    chk("timeout_err", int'(bus.TIMEOUT_ERR), int'(m_tmo));
  endtask

  task automatic wait_strobes(input string name, input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(strobe_cnt >= target), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.BUSY && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(bus.BUSY), 0);
  endtask

  task automatic push_one(input byte unsigned d);
    bus.PUSH = 1'b1;
    bus.PUSH_DATA = d;
    tick();
    bus.PUSH = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    clr = 1'b1;
    bus.ENABLE = 1'b0;
    bus.PUSH = 1'b0;
    bus.PUSH_DATA = 8'h00;
    bus.SPI_TX_EMPTY = 1'b1;

    // Reset, then idle with the sequencer enabled and nothing queued
    tick();
    clr = 1'b0;
    chk("rst_spi_data", int'(bus.SPI_DATA), 8'h00);
    chk("rst_busy",     int'(bus.BUSY), 0);
    chk("rst_write",    int'(bus.SPI_WRITE), 0);
    bus.ENABLE = 1'b1;
    base = strobe_cnt;
    for (int i = 0; i < 50; i++) tick();
    chk("idle_no_strobe", strobe_cnt, base);

    // Vector table: single-byte latency, then fill to full and overflow with ENABLE low
    add(1, 1, 8'hA5, 1, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h00);
    add(1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'hA5);
    for (int r = 3; r <= 11; r++) add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'hA5);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'hA5);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 8'(k), k, (k == 8), 0, 0, 0, 0, 8'hA5);
    add(0, 1, 8'hFF, 8, 1, 0, 1, 0, 0, 8'hA5);
    add(0, 0, 8'h00, 8, 1, 0, 1, 0, 0, 8'hA5);

    foreach (vt[i]) begin
      bus.ENABLE    = vt[i].en;
      bus.PUSH      = vt[i].push;
      bus.PUSH_DATA = vt[i].din;
      tick();
      chk($sformatf("vec%0d_count", i), int'(bus.COUNT), vt[i].cnt);
      chk($sformatf("vec%0d_full", i),  int'(bus.FULL), int'(vt[i].full));
      chk($sformatf("vec%0d_empty", i), int'(bus.EMPTY), int'(vt[i].empty));
      chk($sformatf("vec%0d_ovf", i),   int'(bus.OVERFLOW), int'(vt[i].ovf));
      chk($sformatf("vec%0d_write", i), int'(bus.SPI_WRITE), int'(vt[i].wr));
      chk($sformatf("vec%0d_busy", i),  int'(bus.BUSY), int'(vt[i].busy));
      chk($sformatf("vec%0d_sdata", i), int'(bus.SPI_DATA), int'(vt[i].sdata));
    end
    bus.PUSH = 1'b0;

    // Drain the full FIFO, pushing 09 and 0A while draining so the write pointer wraps
    sent_q.delete();
    base = strobe_cnt;
    bus.ENABLE = 1'b1;
    wait_strobes("drain_first", base + 1, 20);
    push_one(8'h09);
    wait_strobes("drain_second", base + 2, 20);
    push_one(8'h0A);
    wait_strobes("drain_all", base + 10, 200);
    wait_idle("drain_idle", 40);
    chk("drain_sent_n", sent_q.size(), 10);
    for (int k = 0; k < 10 && k < sent_q.size(); k++)
      chk($sformatf("drain_order%0d", k), int'(sent_q[k]), k + 1);

    // Handshake timeout with a silent sender, then normal recovery
    mute = 1'b1;
    base = strobe_cnt;
    push_one(8'h3C);
    wait_strobes("tmo_strobe", base + 1, 10);
    n = 0;
    while (!bus.TIMEOUT_ERR && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_busy", int'(bus.BUSY), 0);
    mute = 1'b0;
    sent_q.delete();
    push_one(8'h5A);
    wait_strobes("tmo_recover", base + 2, 10);
    chk("tmo_recover_data", int'(sent_q.size() != 0 ? sent_q[sent_q.size()-1] : 8'h00), 8'h5A);
    wait_idle("tmo_idle", 40);

    // Push during the LOAD cycle keeps COUNT at 3 and the new byte goes last
    bus.ENABLE = 1'b0;
    push_one(8'hB1);
    push_one(8'hB2);
    push_one(8'hB3);
    chk("pp_count_pre", int'(bus.COUNT), 3);
    sent_q.delete();
    base = strobe_cnt;
    bus.ENABLE = 1'b1;
    tick();
    chk("pp_load_busy",  int'(bus.BUSY), 1);
    chk("pp_load_write", int'(bus.SPI_WRITE), 0);
    push_one(8'hB4);
    chk("pp_count",  int'(bus.COUNT), 3);
    chk("pp_write",  int'(bus.SPI_WRITE), 1);
    chk("pp_data",   int'(bus.SPI_DATA), 8'hB1);
    wait_strobes("pp_drain", base + 4, 100);
    wait_idle("pp_idle", 40);
    chk("pp_sent_n", sent_q.size(), 4);
    for (int k = 0; k < 4 && k < sent_q.size(); k++)
      chk($sformatf("pp_order%0d", k), int'(sent_q[k]), 8'hB1 + k);

    // CLR during WAIT_DONE with four bytes still queued
    bus.ENABLE = 1'b0;
    for (int k = 0; k < 5; k++) push_one(8'(8'hC1 + k));
    base = strobe_cnt;
    bus.ENABLE = 1'b1;
    wait_strobes("rst_mid_strobe", base + 1, 10);
    n = 0;
    while (bus.SPI_TX_EMPTY && n < 10) begin
      tick();
      n++;
    end
    tick();
    chk("rst_mid_pre_count", int'(bus.COUNT), 4);
    chk("rst_mid_pre_busy",  int'(bus.BUSY), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rst_mid_count", int'(bus.COUNT), 0);
    chk("rst_mid_busy",  int'(bus.BUSY), 0);
    chk("rst_mid_ovf",   int'(bus.OVERFLOW), 0);
    chk("rst_mid_tmo",   int'(bus.TIMEOUT_ERR), 0);
    chk("rst_mid_sdata", int'(bus.SPI_DATA), 8'h00);
    base = strobe_cnt;
    for (int i = 0; i < 30; i++) tick();
    chk("rst_mid_no_strobe", strobe_cnt, base);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      bus.ENABLE    = ($urandom_range(0, 9) != 0);
      bus.PUSH      = ($urandom_range(0, 9) < 4);
      bus.PUSH_DATA = 8'($urandom);
      ack_delay     = $urandom_range(1, 4);
      shift_len     = $urandom_range(1, 10);
      tick();
    end
    bus.PUSH   = 1'b0;
    bus.ENABLE = 1'b1;
    n = 0;
    while ((mq.size() != 0 || bus.BUSY) && n < 400) begin
      tick();
      n++;
    end
    chk("rand_drained", mq.size(), 0);
    chk("rand_idle", int'(bus.BUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_feeder.md
Name: spi_tx_feeder

Overview:
Host-side transmit byte queue and pacing sequencer that sits directly upstream of the SPI interface block. Host logic pushes bytes into a small circular FIFO. The sequencer presents one byte at a time on the interface's WRITE/INCOMING_DATA inputs and waits for the sender to accept it and drain before releasing the next. It reports occupancy, a sticky overflow flag and a sticky handshake-timeout error.

Parameters:
DEPTH, 8, number of byte entries in the FIFO (power of two).
AW, 3, pointer width, log2(DEPTH).
TIMEOUT, 16, cycles allowed for the sender to leave empty state after a write strobe.

Ports:
CLK  input  1  system clock; all state updates on its rising edge.
CLR  input  1  synchronous active-high reset.
ENABLE  input  1  1 = sequencer may issue bytes; 0 = hold in IDLE, FIFO still accepts pushes.
PUSH  input  1  host push strobe, one byte per cycle high.
PUSH_DATA  input  8  byte to enqueue.
FULL  output  1  COUNT == DEPTH.
EMPTY  output  1  COUNT == 0.
COUNT  output  AW+1  current occupancy, 0..DEPTH.
SPI_WRITE  output  1  one-cycle write strobe to the interface WRITE input.
SPI_DATA  output  8  byte to the interface INCOMING_DATA input; valid while SPI_WRITE = 1.
SPI_TX_EMPTY  input  1  sender-empty status bit from the interface STATUS bus.
BUSY  output  1  high when the FSM is not in IDLE.
OVERFLOW  output  1  sticky; set on a push while FULL.
TIMEOUT_ERR  output  1  sticky; set when a handshake times out.

Behaviour:
- Reset (CLR = 1 at a CLK edge):
  - Read/write pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0.
  - SPI_WRITE = 0, SPI_DATA = 8'h00, BUSY = 0, OVERFLOW = 0, TIMEOUT_ERR = 0.
  - FSM = IDLE, timeout counter = 0.
  - CLR overrides every other input in the same cycle, including mid-transfer; FIFO contents are discarded.
- FIFO:
  - Push accepted when PUSH = 1 and FULL = 0: write at wptr, wptr increments modulo DEPTH.
  - Push while FULL is dropped and sets OVERFLOW. This holds even if a pop occurs in the same cycle, because FULL is evaluated before the pop.
  - Pop happens only in the LOAD state: rptr increments modulo DEPTH.
  - Push and pop in the same cycle (not full): COUNT unchanged.
  - Pointers wrap with no gap; COUNT never exceeds DEPTH or goes below 0.
  - All status outputs are registered; they reflect the state after the last edge.
- FSM states:
  - IDLE:
    - If ENABLE = 1, EMPTY = 0 and SPI_TX_EMPTY = 1, go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD (exactly 1 cycle):
    - SPI_WRITE = 1, SPI_DATA = FIFO head, pop the head.
    - Clear the timeout counter, then go to WAIT_ACK.
  - WAIT_ACK:
    - SPI_TX_EMPTY = 0 means the sender accepted the byte: go to WAIT_DONE.
    - Otherwise increment the counter; when it reaches TIMEOUT, set TIMEOUT_ERR and go to IDLE. The popped byte is lost.
  - WAIT_DONE:
    - SPI_TX_EMPTY = 1 means the byte has been shifted out: go to IDLE.
    - No timeout in this state.
- Latency and throughput:
  - A push into an empty FIFO with the sender idle gives SPI_WRITE = 1 on the 2nd edge after the push edge.
  - Minimum spacing between SPI_WRITE strobes is 4 cycles (LOAD, WAIT_ACK, WAIT_DONE, IDLE).
- ENABLE:
  - ENABLE dropping mid-transfer does not abort; the current byte completes to IDLE.
  - No new LOAD occurs until ENABLE = 1 again.
- Outputs:
  - SPI_WRITE is never high for two consecutive cycles.
  - SPI_DATA holds its last value when SPI_WRITE = 0.
  - Sticky flags clear only on CLR.

Test Plan:
1. Reset then idle: CLR 1 cycle, SPI_TX_EMPTY = 1, no push -> EMPTY = 1, COUNT = 0, SPI_WRITE never asserted over 50 cycles.
2. Single byte: ENABLE = 1, push 8'hA5; model drops SPI_TX_EMPTY 1 cycle after the strobe and raises it 8 cycles later -> one SPI_WRITE pulse with SPI_DATA = 8'hA5 two edges after the push; BUSY returns to 0; COUNT = 0.
3. Fill and wrap: ENABLE = 0, push 8 bytes 8'h01..8'h08, then a 9th push 8'hFF -> FULL = 1, COUNT = 8, OVERFLOW = 1. Set ENABLE = 1 -> strobes carry 01..08 in order; push 8'h09/8'h0A during draining and both are sent after 08 (pointer wrap).
4. Timeout: push 8'h3C, model keeps SPI_TX_EMPTY = 1 -> TIMEOUT_ERR = 1 exactly TIMEOUT cycles after WAIT_ACK is entered; FSM returns to IDLE; the next byte is issued normally.
5. Simultaneous push and pop: with COUNT = 3, push during the LOAD cycle -> COUNT stays 3; the pushed byte is sent last.
6. Reset mid-transfer: assert CLR during WAIT_DONE with COUNT = 4 -> next cycle COUNT = 0, BUSY = 0, OVERFLOW = 0, TIMEOUT_ERR = 0, and no further SPI_WRITE.
